calpoc_button_conditioner: RTL and testbench
============================================

Name: calpoc_button_conditioner

Overview:
Front end that sits between the six raw board push-buttons and the calculator FSM. It turns asynchronous, bouncy, active-high raw buttons into the clean single-cycle press pulses the FSM consumes on ButtonFor1/0/OR/XOR/Equals/Clear. Per button it synchronises and debounces the input, then edge-detects it. A single-key rollover lockout ensures the FSM never sees two presses in one cycle or a press while another key is still held. It also drives a 3-bit key code with a valid strobe for debug LEDs.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a new level must hold before it is accepted (hardware build uses 500000); must be ≥1 and < 2^CNT_W
CNT_W, 20, width of each per-button debounce counter

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
RawButton1  input  1  raw "1" button, asynchronous, active-high
RawButton0  input  1  raw "0" button
RawButtonOR  input  1  raw OR button
RawButtonXOR  input  1  raw XOR button
RawButtonEquals  input  1  raw Equals button
RawButtonClear  input  1  raw Clear button
ButtonFor1  output  1  one-cycle press pulse to the FSM
ButtonFor0  output  1  one-cycle press pulse
ButtonForOR  output  1  one-cycle press pulse
ButtonForXOR  output  1  one-cycle press pulse
ButtonForEquals  output  1  one-cycle press pulse
ButtonForClear  output  1  one-cycle press pulse
KeyCode  output  3  code of last accepted key: 0="0", 1="1", 2=OR, 3=XOR, 4=Equals, 5=Clear
KeyValid  output  1  high in the same cycle as any ButtonFor* pulse

Behaviour:
- Reset: asynchronous, active-low. While RST_N=0, all synchroniser flops, debounced levels, previous-level flops and counters are 0, state=IDLE, and all outputs are 0, including KeyCode=0. All outputs are registered.
- Synchroniser: each raw input passes through 2 flops (Sync1 -> Sync2).
- Debounce, per button:
  - Stable level Deb and counter Cnt.
  - If Sync2==Deb: Cnt<=0.
  - Else if Cnt==DEBOUNCE_CYCLES-1: Deb<=Sync2 and Cnt<=0.
  - Else: Cnt<=Cnt+1.
  - Any reversion of Sync2 to Deb before acceptance restarts the count, so pulses shorter than DEBOUNCE_CYCLES are discarded.
- Edge detect: Rise[i] = Deb[i] & ~DebPrev[i]. DebPrev is Deb delayed 1 cycle.
- Latency: take edge 0 as the first clock edge that samples the raw input high, with the input stable from then on. The corresponding ButtonFor* is high for exactly one cycle, starting after edge 2+DEBOUNCE_CYCLES (edge 6 at default).
- Lockout FSM:
  - IDLE: if any Rise is set, accept the highest-priority rising button: Clear > Equals > XOR > OR > 0 > 1. Pulse its ButtonFor* and KeyValid for one cycle, load KeyCode, and go to HELD. Lower-priority simultaneous rises are dropped, not queued.
  - HELD: no pulses. Rises from other buttons are ignored permanently, not queued. Return to IDLE in the cycle after all six Deb are 0.
  - A button already held when entering IDLE produces no pulse; only a new rise does.
- KeyCode holds its value between presses. It changes only on an accepted press or on reset.
- At most one ButtonFor* is high in any cycle. KeyValid equals the OR of all six pulses.
- Reset mid-operation: all in-flight debounce progress is lost and no pulse is emitted. A button held through reset release is debounced afresh and pulses once, after edge 2+DEBOUNCE_CYCLES, counting edge 0 as the first edge after RST_N rises.
- Release is debounced identically, but release generates no pulse.

Test Plan:
1. RST_N low 3 cycles then high; all raw low -> every output 0 and KeyCode=0 throughout.
2. RawButton1 high from edge 0 for 20 cycles (DEBOUNCE_CYCLES=4) -> ButtonFor1=1 and KeyValid=1 only in the cycle after edge 6, KeyCode=1 from then on; release produces no pulse.
3. RawButtonOR bounces 1,0,1,0 (one cycle each) then stays high -> exactly one ButtonForOR pulse, 6 edges after the final rising sample. Separately, a 3-cycle glitch on RawButton0 -> no pulse.
4. RawButtonClear and RawButton1 rise on the same edge -> only ButtonForClear pulses, KeyCode=5. Release both, wait 10 cycles, press RawButton0 -> ButtonFor0 pulse, KeyCode=0.
5. Hold RawButtonOR, then press RawButtonXOR 10 cycles later -> only ButtonForOR pulses. Release OR while XOR is still held -> no pulse. Release XOR, wait, press XOR again -> ButtonForXOR pulse, KeyCode=3.
6. RawButtonEquals high from edge 0; RST_N low at edge 3 for 2 cycles -> no pulse before or during reset. With raw still high, ButtonForEquals pulses once after the 6th edge following RST_N release.

Source files
------------

// File: rtl/calpoc_button_conditioner.sv
// Conditions six raw push-buttons into single-cycle press pulses for the calculator FSM:
// 2-flop synchroniser, counter debounce, rising-edge detect and a single-key rollover lockout.
module calpoc_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RawButton1,
  input  logic       RawButton0,
  input  logic       RawButtonOR,
  input  logic       RawButtonXOR,
  input  logic       RawButtonEquals,
  input  logic       RawButtonClear,
  output logic       ButtonFor1,
  output logic       ButtonFor0,
  output logic       ButtonForOR,
  output logic       ButtonForXOR,
  output logic       ButtonForEquals,
  output logic       ButtonForClear,
  output logic [2:0] KeyCode,
  output logic       KeyValid
);

  localparam int NB = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_HELD
  } state_t;

  // Bit index of each button equals its KeyCode.
  logic [NB-1:0] w_raw;
  logic [NB-1:0] w_deb;
  logic [NB-1:0] w_rise;
  logic [NB-1:0] r_deb_prev;

  state_t        r_state;
  state_t        w_state_next;
  logic [NB-1:0] r_pulse;
  logic [NB-1:0] w_pulse_next;
  logic [2:0]    r_key_code;
  logic [2:0]    w_key_code_next;
  logic          r_key_valid;

  assign w_raw = {RawButtonClear, RawButtonEquals, RawButtonXOR,
                  RawButtonOR, RawButton1, RawButton0};

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_btn
      logic             r_sync1;
      logic             r_sync2;
      logic             r_deb;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_deb   <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_raw[gi];
          r_sync2 <= r_sync1;
          // Any return to the accepted level restarts the qualification window.
          if (r_sync2 == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign w_deb[gi] = r_deb;
    end
  endgenerate

  assign w_rise = w_deb & ~r_deb_prev;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_deb_prev  <= '0;
      r_state     <= S_IDLE;
      r_pulse     <= '0;
      r_key_code  <= 3'd0;
      r_key_valid <= 1'b0;
    end else begin
      r_deb_prev  <= w_deb;
      r_state     <= w_state_next;
      r_pulse     <= w_pulse_next;
      r_key_code  <= w_key_code_next;
      r_key_valid <= |w_pulse_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pulse_next    = '0;
    w_key_code_next = r_key_code;
    case (r_state)
      S_IDLE: begin
        if (|w_rise) begin
          w_state_next = S_HELD;
          // Priority is Clear > Equals > XOR > OR > 0 > 1; losers are dropped.
          if (w_rise[5]) begin
            w_pulse_next[5] = 1'b1;
            w_key_code_next = 3'd5;
          end else if (w_rise[4]) begin
            w_pulse_next[4] = 1'b1;
            w_key_code_next = 3'd4;
          end else if (w_rise[3]) begin
            w_pulse_next[3] = 1'b1;
            w_key_code_next = 3'd3;
          end else if (w_rise[2]) begin
            w_pulse_next[2] = 1'b1;
            w_key_code_next = 3'd2;
          end else if (w_rise[0]) begin
            w_pulse_next[0] = 1'b1;
            w_key_code_next = 3'd0;
          end else begin
            w_pulse_next[1] = 1'b1;
            w_key_code_next = 3'd1;
          end
        end
      end
      S_HELD: begin
        if (~|w_deb) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign ButtonFor0      = r_pulse[0];
  assign ButtonFor1      = r_pulse[1];
  assign ButtonForOR     = r_pulse[2];
  assign ButtonForXOR    = r_pulse[3];
  assign ButtonForEquals = r_pulse[4];
  assign ButtonForClear  = r_pulse[5];
  assign KeyCode         = r_key_code;
  assign KeyValid        = r_key_valid;

endmodule

// File: tb/tb_calpoc_button_conditioner.sv
// Cycle-by-cycle vector table for calpoc_button_conditioner; expected pulses are placed by hand
// at edge 2+DEBOUNCE_CYCLES after each accepted raw rise (DEBOUNCE_CYCLES=4).
module tb_calpoc_button_conditioner;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       RawButton1 = 1'b0;
  logic       RawButton0 = 1'b0;
  logic       RawButtonOR = 1'b0;
  logic       RawButtonXOR = 1'b0;
  logic       RawButtonEquals = 1'b0;
  logic       RawButtonClear = 1'b0;
  logic       ButtonFor1;
  logic       ButtonFor0;
  logic       ButtonForOR;
  logic       ButtonForXOR;
  logic       ButtonForEquals;
  logic       ButtonForClear;
  logic [2:0] KeyCode;
  logic       KeyValid;

  calpoc_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(20)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .RawButton1(RawButton1),
    .RawButton0(RawButton0),
    .RawButtonOR(RawButtonOR),
    .RawButtonXOR(RawButtonXOR),
    .RawButtonEquals(RawButtonEquals),
    .RawButtonClear(RawButtonClear),
    .ButtonFor1(ButtonFor1),
    .ButtonFor0(ButtonFor0),
    .ButtonForOR(ButtonForOR),
    .ButtonForXOR(ButtonForXOR),
    .ButtonForEquals(ButtonForEquals),
    .ButtonForClear(ButtonForClear),
    .KeyCode(KeyCode),
    .KeyValid(KeyValid)
  );

  always #5 CLK = ~CLK;

  // Bit index = key code: 0="0", 1="1", 2=OR, 3=XOR, 4=Equals, 5=Clear.
  localparam logic [5:0] K0  = 6'b000001;
  localparam logic [5:0] K1  = 6'b000010;
  localparam logic [5:0] KOR = 6'b000100;
  localparam logic [5:0] KXR = 6'b001000;
  localparam logic [5:0] KEQ = 6'b010000;
  localparam logic [5:0] KCL = 6'b100000;
  localparam logic [5:0] NONE = 6'b000000;

  typedef struct {
    logic       rst_n;
    logic [5:0] raw;
    logic [5:0] exp_btn;
    logic [2:0] exp_code;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] exp_code_track;
  int         n_checks;
  int         n_fail;

  task automatic hold(input logic rst, input logic [5:0] raw, input int n);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      if (!rst) exp_code_track = 3'd0;
      v.rst_n    = rst;
      v.raw      = raw;
      v.exp_btn  = NONE;
      v.exp_code = exp_code_track;
      vecs.push_back(v);
    end
  endtask

  task automatic pulse(input logic [5:0] raw, input logic [5:0] btn, input logic [2:0] code);
    vec_t v;
    exp_code_track = code;
    v.rst_n    = 1'b1;
    v.raw      = raw;
    v.exp_btn  = btn;
    v.exp_code = code;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  initial begin
    logic [5:0] got_btn;
    n_checks = 0;
    n_fail = 0;
    exp_code_track = 3'd0;

    // 1: reset, idle
    hold(1'b0, NONE, 3);
    hold(1'b1, NONE, 2);
    // 2: single press of "1", pulse at edge 6, release silent
    hold(1'b1, K1, 6);
    pulse(K1, K1, 3'd1);
    hold(1'b1, K1, 13);
    hold(1'b1, NONE, 12);
    // 3a: OR bounces 1,0,1,0 then stays high; pulse 6 edges after final rise
    hold(1'b1, KOR, 1);
    hold(1'b1, NONE, 1);
    hold(1'b1, KOR, 1);
    hold(1'b1, NONE, 1);
    hold(1'b1, KOR, 6);
    pulse(KOR, KOR, 3'd2);
    hold(1'b1, KOR, 5);
    hold(1'b1, NONE, 12);
    // 3b: 3-cycle glitch on "0" is discarded
    hold(1'b1, K0, 3);
    hold(1'b1, NONE, 12);
    // 4: Clear and "1" together -> Clear wins; then "0" alone
    hold(1'b1, KCL | K1, 6);
    pulse(KCL | K1, KCL, 3'd5);
    hold(1'b1, KCL | K1, 5);
    hold(1'b1, NONE, 12);
    hold(1'b1, K0, 6);
    pulse(K0, K0, 3'd0);
    hold(1'b1, K0, 3);
    hold(1'b1, NONE, 12);
    // 5: OR held, XOR pressed later is locked out, OR release silent, fresh XOR accepted
    hold(1'b1, KOR, 6);
    pulse(KOR, KOR, 3'd2);
    hold(1'b1, KOR, 3);
    hold(1'b1, KOR | KXR, 15);
    hold(1'b1, KXR, 15);
    hold(1'b1, NONE, 12);
    hold(1'b1, KXR, 6);
    pulse(KXR, KXR, 3'd3);
    hold(1'b1, KXR, 3);
    hold(1'b1, NONE, 12);
    // 6: Equals held across a mid-debounce reset pulses once, 6 edges after release
    hold(1'b1, KEQ, 3);
    hold(1'b0, KEQ, 2);
    hold(1'b1, KEQ, 6);
    pulse(KEQ, KEQ, 3'd4);
    hold(1'b1, KEQ, 4);
    hold(1'b1, NONE, 12);

    for (int i = 0; i < vecs.size(); i++) begin
      RST_N           = vecs[i].rst_n;
      RawButton0      = vecs[i].raw[0];
      RawButton1      = vecs[i].raw[1];
      RawButtonOR     = vecs[i].raw[2];
      RawButtonXOR    = vecs[i].raw[3];
      RawButtonEquals = vecs[i].raw[4];
      RawButtonClear  = vecs[i].raw[5];
      @(posedge CLK);
      #1;
      got_btn = {ButtonForClear, ButtonForEquals, ButtonForXOR,
                 ButtonForOR, ButtonFor1, ButtonFor0};
      $display("vec %0d rst_n=%0b raw=%06b btn=%06b valid=%0b code=%0d",
               i, vecs[i].rst_n, vecs[i].raw, got_btn, KeyValid, KeyCode);
      check("buttons", i, int'(got_btn), int'(vecs[i].exp_btn));
      check("keyvalid", i, int'(KeyValid), int'(|vecs[i].exp_btn));
      check("keycode", i, int'(KeyCode), int'(vecs[i].exp_code));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
